alu_div_sequencer: RTL and testbench
====================================

// Module: alu_div_sequencer
// PURPOSE
//   Multi-cycle 32-bit integer divider built on the shared CPU ALU; produces no arithmetic of its own beyond shifts/muxing.
//   Requests the ALU via alu_req/alu_gnt, runs one restoring-division step per granted cycle using OP_SUB and the bga flag.
//   Sits beside the execute stage; the pipeline holds while busy and muxes alu_a/alu_b/alu_opcode in on grant.
// PARAMETERS
//   WIDTH    32   operand width; must match ALU width
// PORTS
//   clk          in   1      system clock
//   reset        in   1      synchronous, active-high
//   start        in   1      begin division; sampled only when busy=0
//   sig          in   1      1 = signed (two's complement) division
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result, held until next accepted start
//   remainder    out  WIDTH  result, held until next accepted start
//   div_zero     out  1      registered with done; divisor was 0
//   alu_req      out  1      ALU wanted this cycle
//   alu_gnt      in   1      ALU granted this cycle
//   alu_a        out  WIDTH  ALU operand a
//   alu_b        out  WIDTH  ALU operand b
//   alu_opcode   out  4      always OP_SUB (4'b0100)
//   alu_skip     out  1      always 0
//   alu_sig      out  1      always 0 (magnitude compares)
//   alu_y        in   WIDTH  ALU result (a - b)
//   alu_bga      in   1      ALU flag: b > a
// BEHAVIOUR
//   - Reset: state IDLE; busy, done, div_zero, alu_req = 0; quotient, remainder = 0; alu_a/alu_b = 0.
//   - States: IDLE, NEG_A, NEG_B, ITER, FIX_Q, FIX_R. busy = (state != IDLE).
//   - IDLE + start: capture operands, signs, count=WIDTH-1. divisor==0 -> next cycle done=1, div_zero=1,
//     quotient=all ones, remainder=dividend, stay IDLE. Else sig ? NEG_A : ITER.
//   - alu_req=1 in every non-IDLE state; a state advances only on alu_gnt=1, else holds all regs (stall).
//   - NEG_A: a=0,b=dividend; latch alu_y as |dividend| only if dividend[MSB]. -> NEG_B. NEG_B likewise divisor. -> ITER.
//   - ITER (per grant): {cout,shr} = {rem,dvd[MSB]}; a=shr, b=dvsr; qbit = cout | ~alu_bga;
//     rem <= qbit ? alu_y : shr; dvd <= {dvd<<1 | qbit} (dividend reg reused as quotient); count-1.
//     cout covers 33-bit partial remainder; mod-2^WIDTH ALU result is then exact.
//   - count==0 step: sig ? FIX_Q : finish.
//   - FIX_Q: a=0,b=q; negate if sign(dividend)^sign(divisor). FIX_R: negate rem if sign(dividend). -> finish.
//   - Finish: state IDLE, done=1 for one cycle, results registered same edge, div_zero=0. busy low in done cycle;
//     a start in the done cycle is accepted.
//   - Latency with continuous grant, start accepted at edge N: unsigned done at N+WIDTH+1 (33); signed N+WIDTH+5 (37);
//     each ungranted cycle adds one. Divide-by-zero: done at N+1.
//   - start while busy ignored. Signed 0x80000000 / -1 -> q=0x80000000, r=0 (falls out of magnitude path).
//   - reset mid-operation: immediate return to reset values; partial results discarded, no done.
// STRUCTURE
//   - Shared package: ALU opcode constants (OP_SUB etc., shared with ALU), divider state encoding.
//   - No sub-module; ALU stays external and shared through the req/gnt arbiter in execute.
// TESTING
//   1. unsigned 100/7, gnt=1 -> q=14, r=2, done at N+33, div_zero=0.
//   2. signed -100/7 -> q=0xFFFFFFF2, r=0xFFFFFFFE at N+37; 100/-7 -> q=0xFFFFFFF2, r=2.
//   3. 5/0 (either sig) -> q=0xFFFFFFFF, r=5, div_zero=1, done at N+1; alu_req never asserted.
//   4. signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//   5. 100/7 with gnt low 10 cycles mid-ITER -> same result, done at N+43; regs frozen while stalled.
//   6. start pulsed while busy -> ignored; reset at ITER count 15 -> IDLE, all outputs 0, no done; new start works.

Source files
------------

// File: rtl/alu_div_sequencer_pkg.sv
// rtl/alu_div_sequencer_pkg.sv - ALU opcode constants and divider state encoding
package alu_div_sequencer_pkg;

    // Opcodes understood by the shared execute-stage ALU
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;

    // Divider sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_NEG_A = 3'd1;
    localparam logic [2:0] ST_NEG_B = 3'd2;
    localparam logic [2:0] ST_ITER  = 3'd3;
    localparam logic [2:0] ST_FIX_Q = 3'd4;
    localparam logic [2:0] ST_FIX_R = 3'd5;

endpackage

// File: rtl/alu_div_sequencer.sv
// rtl/alu_div_sequencer.sv - multi-cycle restoring divider sequenced on the shared ALU
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, sig                 begin division (ignored while busy), signed mode
//   dividend, divisor          operands captured on an accepted start
//   busy, done                 operation in progress, one-cycle completion pulse
//   quotient, remainder        results, held until overwritten by the next completion
//   div_zero                   set with done when the divisor was zero
//   alu_req / alu_gnt          shared ALU request / grant
//   alu_a, alu_b, alu_opcode   ALU operands and opcode (always subtract)
//   alu_skip, alu_sig          tied low; compares are unsigned magnitudes
//   alu_y, alu_bga             ALU difference a - b and flag b > a
module alu_div_sequencer
    import alu_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sig,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_skip,
    output logic             alu_sig,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_bga
);

    localparam int CW = $clog2(WIDTH);

    logic [2:0]       state;
    logic [WIDTH-1:0] dvd_r;    // dividend magnitude, shifted out as quotient bits shift in
    logic [WIDTH-1:0] dvsr_r;   // divisor magnitude
    logic [WIDTH-1:0] rem_r;    // partial remainder
    logic [CW-1:0]    count;
    logic             sign_a;   // dividend was negative (signed mode only)
    logic             sign_b;   // divisor was negative (signed mode only)
    logic             sig_r;

    logic [WIDTH-1:0] shr;
    logic             cout;
    logic             qbit;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] q_n;

    assign busy       = (state != ST_IDLE);
    assign alu_req    = busy;
    assign alu_opcode = OP_SUB;
    assign alu_skip   = 1'b0;
    assign alu_sig    = 1'b0;

    always_comb begin
        // The shifted-out remainder MSB makes the partial remainder 33 bits wide;
        // when it is set the remainder certainly exceeds the divisor and the
        // modulo-2^WIDTH difference from the ALU is still the exact result.
        shr   = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
        cout  = rem_r[WIDTH-1];
        qbit  = cout | ~alu_bga;
        rem_n = qbit ? alu_y : shr;
        q_n   = {dvd_r[WIDTH-2:0], qbit};

        alu_a = '0;
        alu_b = '0;
        case (state)
            ST_NEG_A: alu_b = dvd_r;
            ST_NEG_B: alu_b = dvsr_r;
            ST_ITER: begin
                alu_a = shr;
                alu_b = dvsr_r;
            end
            ST_FIX_Q: alu_b = dvd_r;
            ST_FIX_R: alu_b = rem_r;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dvd_r     <= '0;
            dvsr_r    <= '0;
            rem_r     <= '0;
            count     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            sig_r     <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    dvd_r  <= dividend;
                    dvsr_r <= divisor;
                    rem_r  <= '0;
                    count  <= CW'(WIDTH - 1);
                    sign_a <= sig & dividend[WIDTH-1];
                    sign_b <= sig & divisor[WIDTH-1];
                    sig_r  <= sig;
                    if (divisor == '0) begin
                        done      <= 1'b1;
                        div_zero  <= 1'b1;
                        quotient  <= '1;
                        remainder <= dividend;
                    end else begin
                        state <= sig ? ST_NEG_A : ST_ITER;
                    end
                end
            end else if (alu_gnt) begin
                // Without a grant every register holds, stalling the sequence
                case (state)
                    ST_NEG_A: begin
                        if (sign_a) dvd_r <= alu_y;
                        state <= ST_NEG_B;
                    end
                    ST_NEG_B: begin
                        if (sign_b) dvsr_r <= alu_y;
                        state <= ST_ITER;
                    end
                    ST_ITER: begin
                        rem_r <= rem_n;
                        dvd_r <= q_n;
                        count <= count - 1'b1;
                        if (count == '0) begin
                            if (sig_r) begin
                                state <= ST_FIX_Q;
                            end else begin
                                state     <= ST_IDLE;
                                done      <= 1'b1;
                                div_zero  <= 1'b0;
                                quotient  <= q_n;
                                remainder <= rem_n;
                            end
                        end
                    end
                    ST_FIX_Q: begin
                        if (sign_a ^ sign_b) dvd_r <= alu_y;
                        state <= ST_FIX_R;
                    end
                    ST_FIX_R: begin
                        // Remainder takes the sign of the dividend
                        state     <= ST_IDLE;
                        done      <= 1'b1;
                        div_zero  <= 1'b0;
                        quotient  <= dvd_r;
                        remainder <= sign_a ? alu_y : rem_r;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// tb/tb_alu_div_sequencer.sv - self-checking bench for alu_div_sequencer
module tb_alu_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sig;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_skip;
    logic        alu_sig;
    logic [31:0] alu_y;
    logic        alu_bga;

    int checks = 0;
    int errors = 0;

    alu_div_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sig        (sig),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_skip   (alu_skip),
        .alu_sig    (alu_sig),
        .alu_y      (alu_y),
        .alu_bga    (alu_bga)
    );

    // External shared ALU: subtract with unsigned b > a flag
    assign alu_y   = alu_a - alu_b;
    assign alu_bga = (alu_b > alu_a);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires)
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input int stall_at, input int stall_len,
                           input bit poke);
        logic [31:0] eq, er;
        logic        ez;
        int          lat, k, done_k;
        longint      la, lb, lq, lr;
        bit          saw_req;
        logic [31:0] fa, fb;

        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a; ez = 1'b1; lat = 1;
        end else if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            eq = lq[31:0]; er = lr[31:0]; ez = 1'b0; lat = 37 + stall_len;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; lat = 33 + stall_len;
        end

        start = 1'b1; sig = s; dividend = a; divisor = b; alu_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; sig = ~s;
        k = 1; saw_req = 0; fa = '0; fb = '0;
        if (b != 32'd0) check({tag, " busy"}, {31'd0, busy}, 32'd1);
        while (!done && k <= lat + 5) begin
            if (alu_req) saw_req = 1;
            if (k == stall_at) begin fa = alu_a; fb = alu_b; end
            if (stall_len > 0 && k == stall_at + stall_len) begin
                check({tag, " frozen_a"}, alu_a, fa);
                check({tag, " frozen_b"}, alu_b, fb);
            end
            alu_gnt = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
            if (poke && k == 5) begin
                start = 1'b1; dividend = 32'd999; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        start = 1'b0; alu_gnt = 1'b1;
        done_k = done ? k : 0;
        check({tag, " latency"}, done_k, lat);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        if (b == 32'd0) check({tag, " no_req"}, {31'd0, saw_req}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          mode;
        bit          saw_done;

        reset = 1'b1; start = 1'b0; sig = 1'b0; dividend = '0; divisor = '0; alu_gnt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst div_zero", {31'd0, div_zero}, 32'd0);
        check("rst alu_req", {31'd0, alu_req}, 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("opcode", {28'd0, alu_opcode}, 32'h4);
        check("skip_sig", {30'd0, alu_skip, alu_sig}, 32'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 0, 0, 0);
        run_div("s-100_7", 1'b1, -32'sd100, 32'd7, 0, 0, 0);
        run_div("s100_-7", 1'b1, 32'd100, -32'sd7, 0, 0, 0);
        run_div("u5_0", 1'b0, 32'd5, 32'd0, 0, 0, 0);
        run_div("s5_0", 1'b1, 32'd5, 32'd0, 0, 0, 0);
        run_div("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
        run_div("u100_7_stall", 1'b0, 32'd100, 32'd7, 12, 10, 0);
        run_div("u_poke", 1'b0, 32'd100, 32'd7, 0, 0, 1);
        run_div("s_poke", 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 3, 2, 1);
        run_div("u_big_dvsr", 1'b0, 32'hFFFF_FFFE, 32'h8000_0001, 0, 0, 0);

        // Reset in the middle of ITER (count 15 after edge N+16)
        start = 1'b1; sig = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (16) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst quotient", quotient, 32'd0);
        check("midrst remainder", remainder, 32'd0);
        check("midrst alu_req", {31'd0, alu_req}, 32'd0);
        check("midrst alu_b", alu_b, 32'd0);
        saw_done = 0;
        repeat (40) begin
            if (done) saw_done = 1;
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst no_done", {31'd0, saw_done}, 32'd0);
        run_div("after_rst", 1'b0, 32'd100, 32'd7, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 5);
            ra = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
            case (mode)
                0, 1:    rb = $urandom;
                2:       rb = $urandom_range(1, 15);
                3:       rb = -$urandom_range(1, 15);
                4:       rb = $urandom_range(0, 70000);
                default: rb = 32'd0;
            endcase
            run_div($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ra, rb,
                    $urandom_range(1, 20), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
